// File: rtl/multicycle_alu_if.sv
// Handshake and data bundle between the pipeline controller and the
// execution-stage ALU. The controller drives the request side, the ALU
// returns busy/done, the result pair and the completion flags.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_by_zero;
    logic             invalid_op;

    // Controller side: issues requests, observes completion.
    modport master (
        output start, alu_control, op_a, op_b,
        input  busy, done, result, result_hi, zero, div_by_zero, invalid_op
    );

    // ALU side: accepts requests, reports completion.
    modport slave (
        input  start, alu_control, op_a, op_b,
        output busy, done, result, result_hi, zero, div_by_zero, invalid_op
    );
endinterface

// File: rtl/multicycle_alu.sv
// Execution-stage ALU. ADD/SUB/MOV/MOVI, invalid codes and divide-by-zero
// finish in one clock; MULT (unsigned shift-add) and DIV (unsigned
// restoring) iterate once per clock for WIDTH clocks. All outputs are
// registered and only change on completion, so intermediate iterations
// never reach the bus.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_alu_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    // r_opa: multiplier / dividend-then-quotient shift register
    // r_opb: multiplicand / divisor (constant during an operation)
    // r_acc: product high-half accumulator / partial remainder
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_div_by_zero;
    logic             r_invalid_op;

    // Single-cycle result path, evaluated on the request operands.
    logic [WIDTH-1:0] w_sc_result;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_invalid;
    logic             w_sc_dbz;

    // Iterative datapath next values.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi_next;
    logic [WIDTH-1:0] w_mul_lo_next;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_rem_next;
    logic [WIDTH-1:0] w_div_quo_next;

    // Decode the request into the one-cycle result, high word and flags.
    always_comb begin
        w_sc_result  = {WIDTH{1'b0}};
        w_sc_hi      = {WIDTH{1'b0}};
        w_sc_invalid = 1'b0;
        w_sc_dbz     = 1'b0;
        case (bus.alu_control)
            OP_ADD:  w_sc_result = bus.op_a + bus.op_b;
            OP_SUB:  w_sc_result = bus.op_a - bus.op_b;
            OP_MOV:  w_sc_result = bus.op_a;
            OP_MOVI: w_sc_result = bus.op_b;
            OP_MULT: w_sc_result = {WIDTH{1'b0}};
            OP_DIV: begin
                // Only used when the divisor is zero; a non-zero divisor
                // takes the iterative path instead.
                w_sc_result = {WIDTH{1'b1}};
                w_sc_hi     = bus.op_a;
                w_sc_dbz    = 1'b1;
            end
            default: begin
                w_sc_result  = {WIDTH{1'b0}};
                w_sc_invalid = 1'b1;
            end
        endcase
    end

    // One shift-add step: conditionally add the multiplicand to the high
    // half, then shift {high, multiplier} right by one.
    always_comb begin
        if (r_opa[0]) begin
            w_mul_sum = {1'b0, r_acc} + {1'b0, r_opb};
        end else begin
            w_mul_sum = {1'b0, r_acc};
        end
        w_mul_hi_next = w_mul_sum[WIDTH:1];
        w_mul_lo_next = {w_mul_sum[0], r_opa[WIDTH-1:1]};
    end

    // One restoring-division step: bring down the next dividend bit and
    // subtract the divisor when it fits. The difference is below the
    // divisor, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        w_div_shift = {r_acc, r_opa[WIDTH-1]};
        if (w_div_shift >= {1'b0, r_opb}) begin
            w_div_rem_next = w_div_shift[WIDTH-1:0] - r_opb;
            w_div_quo_next = {r_opa[WIDTH-2:0], 1'b1};
        end else begin
            w_div_rem_next = w_div_shift[WIDTH-1:0];
            w_div_quo_next = {r_opa[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {CNT_W{1'b0}};
            r_opa         <= {WIDTH{1'b0}};
            r_opb         <= {WIDTH{1'b0}};
            r_acc         <= {WIDTH{1'b0}};
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= {WIDTH{1'b0}};
            r_result_hi   <= {WIDTH{1'b0}};
            r_zero        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_invalid_op  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.alu_control == OP_MULT) begin
                            r_opa   <= bus.op_a;
                            r_opb   <= bus.op_b;
                            r_acc   <= {WIDTH{1'b0}};
                            r_cnt   <= {CNT_W{1'b0}};
                            r_busy  <= 1'b1;
                            r_state <= ST_MUL;
                        end else if ((bus.alu_control == OP_DIV) &&
                                     (bus.op_b != {WIDTH{1'b0}})) begin
                            r_opa   <= bus.op_a;
                            r_opb   <= bus.op_b;
                            r_acc   <= {WIDTH{1'b0}};
                            r_cnt   <= {CNT_W{1'b0}};
                            r_busy  <= 1'b1;
                            r_state <= ST_DIV;
                        end else begin
                            r_result      <= w_sc_result;
                            r_result_hi   <= w_sc_hi;
                            r_zero        <= (w_sc_result == {WIDTH{1'b0}});
                            r_div_by_zero <= w_sc_dbz;
                            r_invalid_op  <= w_sc_invalid;
                            r_done        <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc <= w_mul_hi_next;
                    r_opa <= w_mul_lo_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_result      <= w_mul_lo_next;
                        r_result_hi   <= w_mul_hi_next;
                        r_zero        <= (w_mul_lo_next == {WIDTH{1'b0}});
                        r_div_by_zero <= 1'b0;
                        r_invalid_op  <= 1'b0;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_state       <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    r_acc <= w_div_rem_next;
                    r_opa <= w_div_quo_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_result      <= w_div_quo_next;
                        r_result_hi   <= w_div_rem_next;
                        r_zero        <= (w_div_quo_next == {WIDTH{1'b0}});
                        r_div_by_zero <= 1'b0;
                        r_invalid_op  <= 1'b0;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.result_hi   = r_result_hi;
    assign bus.zero        = r_zero;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.invalid_op  = r_invalid_op;

endmodule
